// File: rtl/vga_pkg.sv
// Shared timing defaults, derived totals and sizing helpers for the VGA scanout slice.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_TILE_LOG2 = 6;
    localparam int DEF_TILES_X  = 8;
    localparam int DEF_TILES_Y  = 6;
    localparam logic [7:0] DEF_BORDER_COLOR = 8'h00;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int core_idx_width(input int tiles_x, input int tiles_y);
        int n;
        n = tiles_x * tiles_y;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Per-pixel control bits that travel alongside the VRAM read.
    typedef struct packed {
        logic vld;
        logic vis;
        logic in_grid;
        logic hs;
        logic vs;
        logic fs;
    } stage_flags_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with visible flag and raw (active-high) sync windows.
// Latency: outputs are combinational decodes of the counter flops; no backpressure, free-running.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_W      = $clog2(calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP)),
    parameter int V_W      = $clog2(calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP))
) (
    input  logic           clk,
    input  logic           reset,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           visible,
    output logic           hsync_act,
    output logic           vsync_act,
    output logic           frame_first
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SS   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SE   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SS   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SE   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h_d, h_q;
    logic [V_W-1:0] v_d, v_q;

    always_comb begin
        h_d = h_q + H_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h           = h_q;
    assign v           = v_q;
    assign visible     = (h_q < H_VIS) && (v_q < V_VIS);
    assign hsync_act   = (h_q >= H_SS) && (h_q < H_SE);
    assign vsync_act   = (v_q >= V_SS) && (v_q < V_SE);
    assign frame_first = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_vram_scanout.sv
// VGA scanout: broadcasts a tile-local VRAM address to all cores and muxes the owning core's byte.
// Latency: 3 clocks from raster counter to o_rgb/o_de/syncs/o_frame_start, all aligned.
// Backpressure: none; free-running pixel stream, the DAC must accept one pixel per clock.
module vga_vram_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int TILE_LOG2 = DEF_TILE_LOG2,
    parameter int TILES_X   = DEF_TILES_X,
    parameter int TILES_Y   = DEF_TILES_Y,
    parameter logic [7:0] BORDER_COLOR = DEF_BORDER_COLOR,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [2*TILE_LOG2-1:0]       o_VRAM_addr,
    input  logic [TILES_X*TILES_Y*8-1:0] i_VRAM_rd_data,
    output logic [7:0]                   o_rgb,
    output logic                         o_hsync,
    output logic                         o_vsync,
    output logic                         o_de,
    output logic                         o_frame_start
);

    localparam int H_W   = $clog2(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int V_W   = $clog2(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int NCORE = TILES_X * TILES_Y;
    localparam int CI_W  = core_idx_width(TILES_X, TILES_Y);
    localparam logic SYNC_ON = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           vis_raw, hs_raw, vs_raw, first_raw;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_W(H_W), .V_W(V_W)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .h           (h_cnt),
        .v           (v_cnt),
        .visible     (vis_raw),
        .hsync_act   (hs_raw),
        .vsync_act   (vs_raw),
        .frame_first (first_raw)
    );

    // S0 decode: tile coordinates, ownership and tile-local address.
    logic [H_W-1:0]         tx;
    logic [V_W-1:0]         ty;
    logic [CI_W-1:0]        core_idx_raw;
    logic                   in_grid_raw;
    logic [2*TILE_LOG2-1:0] addr_d;
    stage_flags_t           flags_s1_d;

    assign tx          = h_cnt >> TILE_LOG2;
    assign ty          = v_cnt >> TILE_LOG2;
    assign in_grid_raw = vis_raw && (tx < H_W'(TILES_X)) && (ty < V_W'(TILES_Y));
    assign addr_d      = {v_cnt[TILE_LOG2-1:0], h_cnt[TILE_LOG2-1:0]};

    generate
        if (is_pow2(TILES_X)) begin : g_idx_shift
            localparam int XL2 = $clog2(TILES_X);
            assign core_idx_raw = (CI_W'(ty) << XL2) + CI_W'(tx);
        end else begin : g_idx_mul
            assign core_idx_raw = CI_W'(ty) * CI_W'(TILES_X) + CI_W'(tx);
        end
    endgenerate

    always_comb begin
        flags_s1_d         = '0;
        flags_s1_d.vld     = 1'b1;
        flags_s1_d.vis     = vis_raw;
        flags_s1_d.in_grid = in_grid_raw;
        flags_s1_d.hs      = hs_raw;
        flags_s1_d.vs      = vs_raw;
        flags_s1_d.fs      = first_raw;
    end

    logic [2*TILE_LOG2-1:0] addr_q;
    logic [CI_W-1:0]        core_idx_s1_q, core_idx_s2_q;
    stage_flags_t           flags_s1_q, flags_s2_q;

    // S2 -> S3: the cores present the byte for the S1 address now.
    logic [7:0] sel_byte;
    logic [7:0] rgb_d, rgb_q;
    logic       de_d, de_q, hsync_d, hsync_q, vsync_d, vsync_q, fs_d, fs_q;

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NCORE; k++) begin
            if (core_idx_s2_q == CI_W'(k)) begin
                sel_byte = i_VRAM_rd_data[k*8 +: 8];
            end
        end
    end

    always_comb begin
        de_d    = flags_s2_q.vld && flags_s2_q.vis;
        rgb_d   = '0;
        if (de_d) begin
            rgb_d = flags_s2_q.in_grid ? sel_byte : BORDER_COLOR;
        end
        hsync_d = (flags_s2_q.vld && flags_s2_q.hs) ? SYNC_ON : ~SYNC_ON;
        vsync_d = (flags_s2_q.vld && flags_s2_q.vs) ? SYNC_ON : ~SYNC_ON;
        fs_d    = flags_s2_q.vld && flags_s2_q.fs;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q        <= '0;
            core_idx_s1_q <= '0;
            flags_s1_q    <= '0;
            core_idx_s2_q <= '0;
            flags_s2_q    <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            fs_q          <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            core_idx_s1_q <= core_idx_raw;
            flags_s1_q    <= flags_s1_d;
            core_idx_s2_q <= core_idx_s1_q;
            flags_s2_q    <= flags_s1_q;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            fs_q          <= fs_d;
        end
    end

    assign o_VRAM_addr   = addr_q;
    assign o_rgb         = rgb_q;
    assign o_de          = de_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_vram_scanout.sv
// Directed bench on a scaled raster (16-px tiles, 176x120 total) so whole frames fit a short run.
module tb_vga_vram_scanout;

    localparam int HT = 176;
    localparam int VT = 120;
    localparam int FT = HT * VT;
    localparam int NCORE = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]         vram_addr, pol_addr;
    logic [NCORE*8-1:0] vram_dat = '0;
    logic [7:0]         rgb, pol_rgb;
    logic               hs, vs, de, fs, pol_hs, pol_vs, pol_de, pol_fs;

    vga_vram_scanout #(
        .H_ACTIVE(160), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(112), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .TILE_LOG2(4), .TILES_X(8), .TILES_Y(6),
        .BORDER_COLOR(8'h1C), .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(rst_n), .o_VRAM_addr(vram_addr), .i_VRAM_rd_data(vram_dat),
        .o_rgb(rgb), .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_frame_start(fs)
    );

    vga_vram_scanout #(
        .H_ACTIVE(160), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(112), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .TILE_LOG2(4), .TILES_X(8), .TILES_Y(6),
        .BORDER_COLOR(8'h1C), .SYNC_ACTIVE_LOW(1'b0)
    ) dut_pol (
        .clk(clk), .reset(rst_n), .o_VRAM_addr(pol_addr), .i_VRAM_rd_data(vram_dat),
        .o_rgb(pol_rgb), .o_hsync(pol_hs), .o_vsync(pol_vs), .o_de(pol_de), .o_frame_start(pol_fs)
    );

    // VRAM model: core k returns k+1, except core 17 at byte 0x26 returns 0xA5; one-cycle read.
    always @(posedge clk) begin
        for (int k = 0; k < NCORE; k++) begin
            vram_dat[k*8 +: 8] <= (k == 17 && vram_addr == 8'h26) ? 8'hA5 : 8'(k + 1);
        end
    end

    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    task automatic at_cyc(input int t);
        int n = 0;
        while (cyc < t && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != t) begin
            n_chk++;
            $display("FAIL wait_cyc got=%0d exp=%0d", cyc, t);
        end
    endtask

    function automatic int pix(input int h, input int v, input int f);
        return f * FT + v * HT + h;
    endfunction

    task automatic at_pix(input int h, input int v, input int f);
        at_cyc(pix(h, v, f) + 3);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rgb"}, rgb, 8'h00);
        chk({tag, "_de"}, de, 1'b0);
        chk({tag, "_hs"}, hs, 1'b1);
        chk({tag, "_vs"}, vs, 1'b1);
        chk({tag, "_fs"}, fs, 1'b0);
        chk({tag, "_addr"}, vram_addr, 8'h00);
        chk({tag, "_pol_hs"}, pol_hs, 1'b0);
        chk({tag, "_pol_vs"}, pol_vs, 1'b0);
    endtask

    task automatic release_and_check(input string tag);
        rst_n = 1'b1;
        at_cyc(1);
        chk({tag, "_e1_fs"}, fs, 1'b0);
        chk({tag, "_e1_de"}, de, 1'b0);
        chk({tag, "_e1_hs"}, hs, 1'b1);
        at_cyc(2);
        chk({tag, "_e2_fs"}, fs, 1'b0);
        chk({tag, "_e2_rgb"}, rgb, 8'h00);
        at_cyc(3);
        chk({tag, "_e3_fs"}, fs, 1'b1);
        chk({tag, "_e3_de"}, de, 1'b1);
        chk({tag, "_e3_rgb"}, rgb, 8'h01);
    endtask

    // Run-length monitor: 0 hs, 1 vs, 2 pol_hs, 3 pol_vs, 4 frame_start.
    bit meas = 1'b0;
    int wmin[5], wmax[5], pmin[5], pmax[5], last[5], run[5], starts[5];
    bit prev[5];
    initial begin
        bit cur[5];
        for (int i = 0; i < 5; i++) begin
            wmin[i] = 1 << 30; wmax[i] = 0; pmin[i] = 1 << 30; pmax[i] = 0;
            last[i] = -1; run[i] = 0; starts[i] = 0; prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (meas) begin
                cur[0] = (hs == 1'b0);
                cur[1] = (vs == 1'b0);
                cur[2] = (pol_hs == 1'b1);
                cur[3] = (pol_vs == 1'b1);
                cur[4] = (fs == 1'b1);
                for (int i = 0; i < 5; i++) begin
                    if (cur[i]) begin
                        if (!prev[i]) begin
                            starts[i]++;
                            if (last[i] >= 0) begin
                                if (cyc - last[i] < pmin[i]) pmin[i] = cyc - last[i];
                                if (cyc - last[i] > pmax[i]) pmax[i] = cyc - last[i];
                            end
                            last[i] = cyc;
                        end
                        run[i]++;
                    end else if (prev[i]) begin
                        if (run[i] < wmin[i]) wmin[i] = run[i];
                        if (run[i] > wmax[i]) wmax[i] = run[i];
                        run[i] = 0;
                    end
                    prev[i] = cur[i];
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        meas = 1'b1;
        release_and_check("rel0");
        chk("f0_pol_fs", pol_fs, 1'b1);

        at_pix(15, 0, 0);   chk("h15_rgb", rgb, 8'h01);
        at_pix(16, 0, 0);   chk("h16_rgb", rgb, 8'h02);
        at_pix(128, 0, 0);  chk("bord_h128_rgb", rgb, 8'h1C);
                            chk("bord_h128_de", de, 1'b1);
        at_pix(160, 5, 0);  chk("hblank_rgb", rgb, 8'h00);
                            chk("hblank_de", de, 1'b0);
        at_pix(163, 5, 0);  chk("hs_pre", hs, 1'b1);
        at_pix(164, 5, 0);  chk("hs_first", hs, 1'b0);
                            chk("pol_hs_first", pol_hs, 1'b1);
        at_pix(171, 5, 0);  chk("hs_last", hs, 1'b0);
        at_pix(172, 5, 0);  chk("hs_post", hs, 1'b1);
        at_pix(175, 5, 0);  chk("hblank_end_rgb", rgb, 8'h00);
        at_pix(0, 16, 0);   chk("v16_rgb", rgb, 8'h09);
        at_cyc(pix(22, 34, 0) + 1);
        chk("addr_22_34", vram_addr, 8'h26);
        chk("pol_addr_22_34", pol_addr, 8'h26);
        at_pix(22, 34, 0);  chk("pix_22_34", rgb, 8'hA5);
                            chk("pol_pix_22_34", pol_rgb, 8'hA5);
                            chk("pol_de_22_34", pol_de, 1'b1);
        at_pix(23, 34, 0);  chk("pix_23_34", rgb, 8'h12);
        at_pix(159, 95, 0); chk("bord_159_95", rgb, 8'h1C);
        at_pix(0, 96, 0);   chk("bord_v96_rgb", rgb, 8'h1C);
                            chk("bord_v96_de", de, 1'b1);
        at_pix(100, 111, 0); chk("bord_v111", rgb, 8'h1C);
        at_pix(0, 112, 0);  chk("vblank_rgb", rgb, 8'h00);
                            chk("vblank_de", de, 1'b0);
        at_pix(0, 113, 0);  chk("vs_pre", vs, 1'b1);
        at_pix(0, 114, 0);  chk("vs_first", vs, 1'b0);
                            chk("pol_vs_first", pol_vs, 1'b1);
        at_pix(175, 115, 0); chk("vs_last", vs, 1'b0);
        at_pix(0, 116, 0);  chk("vs_post", vs, 1'b1);

        at_cyc(2 * FT + 3 + 400);
        meas = 1'b0;
        chk("hs_w_min", wmin[0], 8);     chk("hs_w_max", wmax[0], 8);
        chk("hs_p_min", pmin[0], HT);    chk("hs_p_max", pmax[0], HT);
        chk("vs_w_min", wmin[1], 2 * HT); chk("vs_w_max", wmax[1], 2 * HT);
        chk("vs_p", pmax[1], FT);        chk("vs_runs", starts[1], 2);
        chk("pol_hs_w_min", wmin[2], 8); chk("pol_hs_w_max", wmax[2], 8);
        chk("pol_hs_p", pmax[2], HT);
        chk("pol_vs_w", wmax[3], 2 * HT); chk("pol_vs_w_min", wmin[3], 2 * HT);
        chk("fs_width", wmax[4], 1);
        chk("fs_p_min", pmin[4], FT);    chk("fs_p_max", pmax[4], FT);
        chk("fs_count", starts[4], 3);

        at_cyc(pix(60, 40, 2));
        chk("pre_rst_rgb", rgb, 8'd20);
        chk("pre_rst_de", de, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        release_and_check("rel1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_vram_scanout.md
# vga_vram_scanout

Single-clock VGA scanout engine. It reads the per-core VRAM tiles through each core's VGA read port (12-bit byte address in, 8-bit pixel out, one-cycle registered latency) and produces a 640x480 RGB332 pixel stream with hsync/vsync. One shared address is broadcast to every core. The block then selects the byte from whichever core owns the current screen tile. It sits at the top level in the VGA clock domain and feeds the board's video DAC.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porch and sync widths, in pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porch and sync widths, in lines
- TILE_LOG2, 6: tile side is 2^TILE_LOG2 pixels; a tile is 4096 bytes, matching one core's VRAM
- TILES_X, 8 / TILES_Y, 6: core tile grid, row-major; core index = ty*TILES_X + tx
- BORDER_COLOR, 8'h00: pixel value outside the tile grid
- SYNC_ACTIVE_LOW, 1: sync polarity

Ports:
- clk, input, 1: pixel clock (clkvga domain)
- reset, input, 1: asynchronous, active-low
- o_VRAM_addr, output, 12: byte address broadcast to all cores' VRAM read ports
- i_VRAM_rd_data, input, TILES_X*TILES_Y*8: byte from each core; core k occupies bits [8k+7:8k]
- o_rgb, output, 8: RGB332 pixel; 0 during blanking
- o_hsync, output, 1: horizontal sync
- o_vsync, output, 1: vertical sync
- o_de, output, 1: data enable (visible region)
- o_frame_start, output, 1: one-cycle pulse aligned with pixel (0,0) on o_rgb

## Operation
- Counters: h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - At wrap, h goes to 0 and v increments.
  - v counts 0..V_TOTAL-1 (525) and wraps to 0.
- Visible region: h<H_ACTIVE and v<V_ACTIVE.
- Sync windows:
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted on the same rule applied to v.
  - When SYNC_ACTIVE_LOW=1, an asserted sync drives the pin to 0.
- Tile mapping:
  - tx = h>>TILE_LOG2, ty = v>>TILE_LOG2.
  - in_grid = visible && tx<TILES_X && ty<TILES_Y.
- Address: o_VRAM_addr = {v[TILE_LOG2-1:0], h[TILE_LOG2-1:0]} (row-major within the tile).
- Pixel selection:
  - Select byte core_idx of i_VRAM_rd_data.
  - If visible but not in_grid, output BORDER_COLOR.
  - If not visible, output 0.
- core_idx is computed with a multiplier-free add, (ty<<log2 TILES_X)+tx, only when TILES_X is a power of two. Otherwise use a constant multiply; its width is $clog2(TILES_X*TILES_Y).

## Timing
- Pipeline stage S0: counters hold (h,v).
- Pipeline stage S1: o_VRAM_addr, core_idx, in_grid, visible and sync flags are registered.
- Pipeline stage S2: the core VRAM presents the byte for the S1 address (one-cycle latency); select flags are delayed one stage.
- Pipeline stage S3: o_rgb, o_de, o_hsync, o_vsync and o_frame_start are registered together.
- Fixed latency is 3 clocks from counter value to outputs. All outputs stay mutually aligned.
- Reset values:
  - h=v=0; o_VRAM_addr=0; o_rgb=0; o_de=0; o_frame_start=0.
  - o_hsync and o_vsync at their inactive level (1 when SYNC_ACTIVE_LOW).
  - All pipeline valid flags are 0.
- First frame after reset release:
  - o_frame_start first pulses 3 clocks after the first clk edge with reset high.
  - Before that pulse, outputs hold reset values.
- Reset mid-frame: all stages clear immediately (asynchronous). No partial pixel is emitted after reset asserts.
- Wrap-around:
  - The last pixel (799,524) is followed directly by (0,0).
  - o_frame_start pulses once per 800*525 = 420000 clocks.

## Structure
- vga_pkg holds the timing defaults, the H_TOTAL/V_TOTAL derivations, and a function for core index width.
- Sub-module vga_timing_gen holds the h/v counters, visible flag and raw sync generation.
- vga_vram_scanout instantiates vga_timing_gen and holds the address/select pipeline plus the output registers.

## Test plan
- Frame timing: run 2 frames after reset.
  - o_hsync low for exactly 96 clocks every 800.
  - o_vsync low for exactly 2 lines (1600 clocks) every 420000.
  - o_frame_start period is 420000.
- Addressing: at counter (h=70,v=130) o_VRAM_addr = {6'd2,6'd6} = 12'h086. The VRAM model for core 2*8+1=17 returns 8'hA5, which appears on o_rgb 3 clocks later.
- Tile boundary: each core k returns constant k+1.
  - Pixel at h=63 outputs core 0's value; h=64 outputs core 1's value, on consecutive clocks.
  - Line v=64 starts with core 8's value.
- Border/blanking: BORDER_COLOR=8'h1C.
  - h=512..639 with v<384 gives 8'h1C with o_de=1.
  - v=384..479 gives 8'h1C.
  - h>=640 gives o_rgb=0 with o_de=0.
- Reset mid-frame: assert reset at (h=300,v=200). Outputs go to reset values within the same cycle, with no clock edge needed. After release, o_frame_start occurs 3 clocks after the first edge.
- Polarity: SYNC_ACTIVE_LOW=0 gives o_hsync/o_vsync idle low and pulsing high with identical widths.
